snes_event_queue: RTL

Buffers SNES controller input for the control FSM. Sits between the SNES serial reader, which produces a 12-bit active-high button vector, and the FSM, which polls for input. Resynchronises and filters the vector, turns press and release edges into one event per button, and queues the events in a FIFO. The FSM pops events with a valid/pop handshake, so it cannot miss short presses between polls.

---
 rtl/snes_event_queue_pkg.sv | 13 +
 rtl/snes_event_queue_event_fifo.sv | 64 ++++++
 rtl/snes_event_queue.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/snes_event_queue_pkg.sv
// Shared types and event-word layout for the SNES controller event queue.
package snes_evt_pkg;

   typedef enum logic {
      IDLE,
      SCAN
   } scan_state_t;

   localparam int EVT_W         = 16;
   localparam int EVT_PRESS_BIT = 15;
   localparam int EVT_IDX_W     = 4;

endpackage

// File: rtl/snes_event_queue_event_fifo.sv
// First-word fall-through event FIFO; a push while full is only taken when a pop frees a slot that cycle.
module event_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     dropped
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dropped = push && !do_push;

   assign valid = !empty;
   assign head  = empty ? '0 : mem[rd_ptr];

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/snes_event_queue.sv
// Resynchronises and debounces the SNES button vector, serialises changes into
// press/release events (lowest index first) and queues them for the control FSM.
module snes_event_queue
   import snes_evt_pkg::*;
#(
   parameter int BUTTONS       = 12,
   parameter int DEPTH         = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BUTTONS-1:0]       btn_in,
   input  logic                     pop,
   input  logic                     clr_overflow,
   output logic                     evt_valid,
   output logic [EVT_W-1:0]         evt_data,
   output logic [BUTTONS-1:0]       btn_state,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int                CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [BUTTONS-1:0]   sync_meta;
   logic [BUTTONS-1:0]   sync;
   logic [BUTTONS-1:0]   cand;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_inc;
   logic                 accept;

   scan_state_t          state;
   scan_state_t          state_next;
   logic [BUTTONS-1:0]   mask;
   logic [BUTTONS-1:0]   mask_next;
   logic [BUTTONS-1:0]   mask_cleared;
   logic [BUTTONS-1:0]   btn_state_next;

   logic [EVT_IDX_W-1:0] scan_idx;
   logic                 scan_press;
   logic                 push;
   logic [EVT_W-1:0]     push_data;
   logic                 dropped;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= '0;
         sync      <= '0;
         cand      <= '0;
         cnt       <= '0;
      end else begin
         sync_meta <= btn_in;
         sync      <= sync_meta;
         if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
         end else begin
            cnt  <= cnt_inc;
         end
      end
   end

   // The current sample counts toward stability, so accept fires on the edge
   // where the incremented count first reaches the threshold.
   assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
   assign accept  = (state == IDLE) && (sync == cand) && (cnt_inc == CNT_MAX)
                    && (cand != btn_state);

   always_comb begin
      scan_idx   = '0;
      scan_press = 1'b0;
      for (int i = BUTTONS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            scan_idx   = EVT_IDX_W'(i);
            scan_press = btn_state[i];
         end
      end
   end

   always_comb begin
      push_data                  = '0;
      push_data[EVT_PRESS_BIT]   = scan_press;
      push_data[EVT_IDX_W-1:0]   = scan_idx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mask      <= '0;
         btn_state <= '0;
      end else begin
         state     <= state_next;
         mask      <= mask_next;
         btn_state <= btn_state_next;
      end
   end

   always_comb begin
      state_next     = state;
      mask_next      = mask;
      btn_state_next = btn_state;
      push           = 1'b0;
      mask_cleared   = mask & ~(BUTTONS'(1) << scan_idx);
      case (state)
         IDLE: begin
            if (accept) begin
               mask_next      = cand ^ btn_state;
               btn_state_next = cand;
               state_next     = SCAN;
            end
         end
         SCAN: begin
            push      = 1'b1;
            mask_next = mask_cleared;
            if (mask_cleared == '0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (dropped) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (evt_data),
      .valid     (evt_valid),
      .count     (count),
      .dropped   (dropped)
   );

endmodule
